// File: rtl/i2c_pkg.sv
// Shared types for the I2C register target: FSM state encoding and ACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Open-drain pad split plus register-file strobes between the I2C target and its host.
interface i2c_reg_target_if;

  logic       scl_i;
  logic       scl_o;
  logic       scl_t;
  logic       sda_i;
  logic       sda_o;
  logic       sda_t;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic       busy;
  logic       addressed;

  modport slave (
    input  scl_i, sda_i, reg_rd_data,
    output scl_o, scl_t, sda_o, sda_t,
    output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
    output busy, addressed
  );

  modport master (
    output scl_i, sda_i, reg_rd_data,
    input  scl_o, scl_t, sda_o, sda_t,
    input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
    input  busy, addressed
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Pad synchroniser plus a run-length deglitcher; emits the accepted level and
// one-cycle rise/fall pulses aligned with the cycle the new level appears.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] run_cnt;
  logic          settle;

  // A new level is accepted once FILTER_LEN consecutive samples disagree with the current one.
  assign settle = (sync[1] != level) && (run_cnt == CW'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      run_cnt <= '0;
      level   <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync <= {sync[0], line_i};
      rise <= settle && sync[1];
      fall <= settle && !sync[1];
      if (sync[1] == level) begin
        run_cnt <= '0;
      end else if (settle) begin
        level   <= sync[1];
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing an 8-bit addressed register space; never stretches SCL,
// only ever pulls SDA low through sda_t.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | driving address ACK during 9th clock
// PTR       | shifting in register pointer
// PTR_ACK   | driving pointer ACK
// WR_DATA   | shifting in write data
// WR_ACK    | driving write-data ACK
// RD_DATA   | shifting out read data
// RD_ACK    | sampling master ACK/NACK
// WAIT_STOP | not for us or read ended; only START/STOP leave
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_reg_target_if.slave     bus
);

  logic fscl, scl_rise, scl_fall;
  logic fsda, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (bus.scl_i),
    .level  (fscl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (bus.sda_i),
    .level  (fsda),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  i2c_tgt_state_t state;
  logic [3:0]     bit_cnt;
  logic [7:0]     shift;
  logic [7:0]     rd_buf;
  logic           rw;
  logic           ack_seen;
  logic           load_direct;
  logic           rd_dly;
  logic           sda_t_q;
  logic [7:0]     reg_addr_q;
  logic [7:0]     reg_wr_data_q;
  logic           reg_wr_en_q;
  logic           reg_rd_en_q;
  logic           busy_q;
  logic           addressed_q;
  logic           start_det;
  logic           stop_det;
  logic [7:0]     shift_in;

  assign start_det = sda_fall && fscl;
  assign stop_det  = sda_rise && fscl;
  assign shift_in  = {shift[6:0], fsda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      rd_buf        <= '0;
      rw            <= 1'b0;
      ack_seen      <= 1'b0;
      load_direct   <= 1'b0;
      rd_dly        <= 1'b0;
      sda_t_q       <= 1'b1;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      addressed_q   <= 1'b0;
    end else begin
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      rd_dly      <= reg_rd_en_q;

      // Read data is valid the cycle after the strobe; the first byte goes straight out.
      if (rd_dly) begin
        rd_buf <= bus.reg_rd_data;
        if (load_direct) begin
          shift       <= bus.reg_rd_data;
          sda_t_q     <= bus.reg_rd_data[7];
          load_direct <= 1'b0;
        end
      end

      if (stop_det) begin
        state       <= IDLE;
        sda_t_q     <= 1'b1;
        busy_q      <= 1'b0;
        addressed_q <= 1'b0;
        load_direct <= 1'b0;
      end else if (start_det) begin
        state       <= ADDR;
        bit_cnt     <= '0;
        sda_t_q     <= 1'b1;
        busy_q      <= 1'b1;
        addressed_q <= 1'b0;
        load_direct <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shift[7:1] == DEV_ADDR && shift[7:1] != 7'h00) begin
                sda_t_q     <= I2C_ACK;
                addressed_q <= 1'b1;
                rw          <= shift[0];
                state       <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                reg_rd_en_q <= 1'b1;
                load_direct <= 1'b1;
                state       <= RD_DATA;
              end else begin
                sda_t_q <= 1'b1;
                state   <= PTR;
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              reg_addr_q <= shift;
              sda_t_q    <= I2C_ACK;
              state      <= PTR_ACK;
            end
          end

          PTR_ACK: begin
            if (scl_fall) begin
              sda_t_q <= 1'b1;
              bit_cnt <= '0;
              state   <= WR_DATA;
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                reg_wr_data_q <= shift_in;
                reg_wr_en_q   <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_t_q <= I2C_ACK;
              state   <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              sda_t_q    <= 1'b1;
              reg_addr_q <= reg_addr_q + 8'd1;
              bit_cnt    <= '0;
              state      <= WR_DATA;
            end
          end

          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_t_q  <= 1'b1;
                ack_seen <= 1'b0;
                state    <= RD_ACK;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_t_q <= shift[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (fsda == I2C_ACK) begin
                reg_addr_q  <= reg_addr_q + 8'd1;
                reg_rd_en_q <= 1'b1;
                ack_seen    <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && ack_seen) begin
              shift   <= rd_buf;
              sda_t_q <= rd_buf[7];
              bit_cnt <= '0;
              state   <= RD_DATA;
            end
          end

          IDLE, WAIT_STOP: begin
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.scl_o       = 1'b1;
  assign bus.scl_t       = 1'b1;
  assign bus.sda_o       = 1'b0;
  assign bus.sda_t       = sda_t_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wr_data = reg_wr_data_q;
  assign bus.reg_wr_en   = reg_wr_en_q;
  assign bus.reg_rd_en   = reg_rd_en_q;
  assign bus.busy        = busy_q;
  assign bus.addressed   = addressed_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench: bit-banged I2C master against i2c_reg_target with a behavioural register file.
`timescale 1ns/1ps
module tb_i2c_reg_target;
  import i2c_pkg::*;

  localparam int QTR = 78;  // prescale 312 clk per SCL period

  logic clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] rd_data_q = 8'h00;

  i2c_reg_target_if bus ();

  assign bus.scl_i       = m_scl & (bus.scl_t | bus.scl_o);
  assign bus.sda_i       = m_sda & (bus.sda_t | bus.sda_o);
  assign bus.reg_rd_data = rd_data_q;

  i2c_reg_target #(.DEV_ADDR(7'h50), .FILTER_LEN(4)) dut (
    .clk   (clk_50mhz),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [7:0] rd_addr_q [$];
  int         strobe_clash = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always @(negedge clk_50mhz) begin
    if (bus.reg_wr_en && bus.reg_rd_en) strobe_clash++;
    if (bus.reg_wr_en) begin
      mem[bus.reg_addr] = bus.reg_wr_data;
      wr_addr_q.push_back(bus.reg_addr);
      wr_data_q.push_back(bus.reg_wr_data);
    end
    if (bus.reg_rd_en) begin
      rd_data_q = mem[bus.reg_addr];
      rd_addr_q.push_back(bus.reg_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic q();
    repeat (QTR) @(negedge clk_50mhz);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; q();
    m_scl = 1'b1; q();
    q();
    m_scl = 1'b0; q();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    b = bus.sda_i; q();
    m_scl = 1'b0; q();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    int         nacks;
    logic [7:0] b0, b1;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    repeat (5) @(negedge clk_50mhz);
    chk("rst_sda_t", bus.sda_t, 1);
    chk("rst_reg_addr", bus.reg_addr, 8'h00);
    chk("rst_wr_data", bus.reg_wr_data, 8'h00);
    chk("rst_strobes", {bus.reg_wr_en, bus.reg_rd_en}, 2'b00);
    chk("rst_busy_addr", {bus.busy, bus.addressed}, 2'b00);
    chk("rst_state", dut.state, IDLE);
    rst_n = 1'b1;
    q();

    // 1: single write 0x10 <= 0xA5
    nacks = 0;
    bus_start();
    put_byte(8'hA0, a); nacks += int'(a);
    chk("t1_addressed", bus.addressed, 1);
    chk("t1_busy", bus.busy, 1);
    put_byte(8'h10, a); nacks += int'(a);
    put_byte(8'hA5, a); nacks += int'(a);
    bus_stop(); q();
    chk("t1_nacks", nacks, 0);
    chk("t1_nwr", wr_addr_q.size(), 1);
    chk("t1_wr_addr", wr_addr_q[0], 8'h10);
    chk("t1_wr_data", wr_data_q[0], 8'hA5);
    chk("t1_ptr_after", bus.reg_addr, 8'h11);
    chk("t1_busy_end", bus.busy, 0);

    // 2: burst write across the pointer wrap
    nacks = 0;
    bus_start();
    put_byte(8'hA0, a); nacks += int'(a);
    put_byte(8'hFE, a); nacks += int'(a);
    put_byte(8'h11, a); nacks += int'(a);
    put_byte(8'h22, a); nacks += int'(a);
    put_byte(8'h33, a); nacks += int'(a);
    bus_stop(); q();
    chk("t2_nacks", nacks, 0);
    chk("t2_nwr", wr_addr_q.size(), 4);
    chk("t2_addr0", wr_addr_q[1], 8'hFE);
    chk("t2_addr1", wr_addr_q[2], 8'hFF);
    chk("t2_addr2", wr_addr_q[3], 8'h00);
    chk("t2_data", {wr_data_q[1], wr_data_q[2], wr_data_q[3]}, 24'h112233);
    chk("t2_ptr_after", bus.reg_addr, 8'h01);

    // 3: pointer write, repeated START, two-byte read ACK then NACK
    nacks = 0;
    bus_start();
    put_byte(8'hA0, a); nacks += int'(a);
    put_byte(8'h20, a); nacks += int'(a);
    bus_start();
    put_byte(8'hA1, a); nacks += int'(a);
    get_byte(b0, I2C_ACK);
    get_byte(b1, I2C_NACK);
    chk("t3_state_wait", dut.state, WAIT_STOP);
    bus_stop(); q();
    chk("t3_nacks", nacks, 0);
    chk("t3_nrd", rd_addr_q.size(), 2);
    chk("t3_rd_addr0", rd_addr_q[0], 8'h20);
    chk("t3_rd_addr1", rd_addr_q[1], 8'h21);
    chk("t3_byte0", b0, 8'h7A);
    chk("t3_byte1", b1, 8'h7B);
    chk("t3_no_wr", wr_addr_q.size(), 4);
    chk("t3_ptr_after", bus.reg_addr, 8'h21);

    // 4: foreign address is ignored
    bus_start();
    put_byte(8'hA2, a);
    chk("t4_nack", a, 1);
    chk("t4_addressed", bus.addressed, 0);
    chk("t4_busy", bus.busy, 1);
    chk("t4_state", dut.state, WAIT_STOP);
    bus_stop(); q();
    chk("t4_busy_end", bus.busy, 0);
    chk("t4_strobes", {8'(wr_addr_q.size()), 8'(rd_addr_q.size())}, {8'd4, 8'd2});

    // 5: reset while the target holds SDA low on a read bit (0x21 holds 0x7B, MSB 0)
    bus_start();
    put_byte(8'hA1, a);
    chk("t5_ack", a, 0);
    chk("t5_driving", bus.sda_t, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_sda_released", bus.sda_t, 1);
    chk("t5_state", dut.state, IDLE);
    chk("t5_reg_addr", bus.reg_addr, 8'h00);
    chk("t5_busy", bus.busy, 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (4) @(negedge clk_50mhz);
    rst_n = 1'b1;
    q();

    // 6: short glitches must be filtered out
    m_sda = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    m_sda = 1'b1;
    q();
    chk("t6_no_start", bus.busy, 0);
    chk("t6_idle", dut.state, IDLE);
    nacks = 0;
    bus_start();
    put_byte(8'hA0, a); nacks += int'(a);
    put_byte(8'h40, a); nacks += int'(a);
    m_sda = 1'b0; q();
    m_scl = 1'b1;
    repeat (2) @(negedge clk_50mhz);
    m_scl = 1'b0; q();
    chk("t6_no_sample", dut.bit_cnt, 0);
    put_byte(8'h3C, a); nacks += int'(a);
    bus_stop(); q();
    chk("t6_nacks", nacks, 0);
    chk("t6_nwr", wr_addr_q.size(), 5);
    chk("t6_wr_addr", wr_addr_q[4], 8'h40);
    chk("t6_wr_data", wr_data_q[4], 8'h3C);

    chk("strobe_clash", strobe_clash, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
